// File: rtl/jedro_1_imem_responder.sv
// Instruction-memory responder for the jedro_1 fetch port. A sequential loader
// fills the array in LOAD; word fetches are answered with a fixed latency in RUN.
module jedro_1_imem_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1,
  localparam int IDX_W = $clog2(DEPTH_WORDS),
  localparam int CNT_W = IDX_W + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  rd_err_o,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  input  logic                  ld_restart_i,
  output logic [CNT_W-1:0]      ld_count_o,
  output logic                  ld_overflow_o,
  output logic                  busy_o
);

  // Handshakes: a loader word transfers on ld_valid_i & ld_ready_o; a fetch is
  // accepted on rd_en_i & rd_gnt_o, and its response is a one-cycle rd_valid_o pulse.
  typedef enum logic {S_LOAD, S_RUN} state_t;

  state_t state_q, state_d;
  logic   flush;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [CNT_W-1:0]      ld_count_q;
  logic                  ld_overflow_q;
  logic                  ld_xfer;
  logic                  ld_in_range;

  logic                  accept;
  logic [IDX_W-1:0]      fetch_idx;
  logic                  fetch_err;
  logic [DATA_WIDTH-1:0] fetch_data;

  logic                  pv [READ_LATENCY];
  logic                  pe [READ_LATENCY];
  logic [DATA_WIDTH-1:0] pd [READ_LATENCY];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ld_ready_o = 1'b0;
    rd_gnt_o   = 1'b0;
    busy_o     = 1'b0;
    flush      = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_ready_o = 1'b1;
        busy_o     = 1'b1;
        if (ld_valid_i && ld_last_i) state_d = S_RUN;
      end
      S_RUN: begin
        rd_gnt_o = 1'b1;
        if (ld_restart_i) begin
          state_d = S_LOAD;
          flush   = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  assign ld_xfer     = ld_valid_i & ld_ready_o;
  assign ld_in_range = ld_count_q < CNT_W'(DEPTH_WORDS);

  // The array is deliberately not reset so an image survives rst_i.
  always_ff @(posedge clk_i) begin
    if (ld_xfer && ld_in_range) mem[ld_count_q[IDX_W-1:0]] <= ld_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ld_count_q    <= '0;
      ld_overflow_q <= 1'b0;
    end else if (flush) begin
      ld_count_q    <= '0;
      ld_overflow_q <= 1'b0;
    end else if (ld_xfer) begin
      if (ld_in_range) ld_count_q    <= ld_count_q + 1'b1;
      else             ld_overflow_q <= 1'b1;
    end
  end

  assign ld_count_o    = ld_count_q;
  assign ld_overflow_o = ld_overflow_q;

  // Any set bit above the word index addresses beyond the array.
  assign accept     = rd_en_i & rd_gnt_o;
  assign fetch_idx  = rd_addr_i[IDX_W+1:2];
  assign fetch_err  = (|rd_addr_i[1:0]) | (|rd_addr_i[ADDR_WIDTH-1:IDX_W+2]);
  assign fetch_data = fetch_err ? '0 : mem[fetch_idx];

  // Data/err stages only load behind a valid entry, so the last stage holds
  // the most recently delivered word while rd_valid_o is low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pe[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= accept & ~flush;
      if (accept && !flush) begin
        pe[0] <= fetch_err;
        pd[0] <= fetch_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1] & ~flush;
        if (pv[i-1] && !flush) begin
          pe[i] <= pe[i-1];
          pd[i] <= pd[i-1];
        end
      end
    end
  end

  assign rd_valid_o = pv[READ_LATENCY-1];
  assign rd_err_o   = pv[READ_LATENCY-1] & pe[READ_LATENCY-1];
  assign rd_data_o  = pd[READ_LATENCY-1];

endmodule

// File: tb/tb_jedro_1_imem_responder.sv
// Directed bench for jedro_1_imem_responder: three instances cover
// (256 words, latency 1), (16 words, latency 3) and (16 words, latency 2).
module tb_jedro_1_imem_responder;

  logic        clk;
  logic        rst        [3];
  logic        rd_en      [3];
  logic [31:0] rd_addr    [3];
  logic        rd_gnt     [3];
  logic [31:0] rd_data    [3];
  logic        rd_valid   [3];
  logic        rd_err     [3];
  logic        ld_valid   [3];
  logic [31:0] ld_data    [3];
  logic        ld_last    [3];
  logic        ld_ready   [3];
  logic        ld_restart [3];
  logic        ld_overflow[3];
  logic        busy       [3];
  logic [8:0]  cnt_a;
  logic [4:0]  cnt_b;
  logic [4:0]  cnt_c;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] img [4];

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, summary %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  jedro_1_imem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr[0]),
    .rd_gnt_o(rd_gnt[0]), .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]),
    .rd_err_o(rd_err[0]), .ld_valid_i(ld_valid[0]), .ld_data_i(ld_data[0]),
    .ld_last_i(ld_last[0]), .ld_ready_o(ld_ready[0]), .ld_restart_i(ld_restart[0]),
    .ld_count_o(cnt_a), .ld_overflow_o(ld_overflow[0]), .busy_o(busy[0]));

  jedro_1_imem_responder #(.DEPTH_WORDS(16), .READ_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr[1]),
    .rd_gnt_o(rd_gnt[1]), .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]),
    .rd_err_o(rd_err[1]), .ld_valid_i(ld_valid[1]), .ld_data_i(ld_data[1]),
    .ld_last_i(ld_last[1]), .ld_ready_o(ld_ready[1]), .ld_restart_i(ld_restart[1]),
    .ld_count_o(cnt_b), .ld_overflow_o(ld_overflow[1]), .busy_o(busy[1]));

  jedro_1_imem_responder #(.DEPTH_WORDS(16), .READ_LATENCY(2)) dut_c (
    .clk_i(clk), .rst_i(rst[2]), .rd_en_i(rd_en[2]), .rd_addr_i(rd_addr[2]),
    .rd_gnt_o(rd_gnt[2]), .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]),
    .rd_err_o(rd_err[2]), .ld_valid_i(ld_valid[2]), .ld_data_i(ld_data[2]),
    .ld_last_i(ld_last[2]), .ld_ready_o(ld_ready[2]), .ld_restart_i(ld_restart[2]),
    .ld_count_o(cnt_c), .ld_overflow_o(ld_overflow[2]), .busy_o(busy[2]));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] count_of(input int k);
    case (k)
      0:       return 32'(cnt_a);
      1:       return 32'(cnt_b);
      default: return 32'(cnt_c);
    endcase
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input int k, input logic [31:0] data, input logic last);
    ld_valid[k] = 1'b1;
    ld_data[k]  = data;
    ld_last[k]  = last;
    step();
    ld_valid[k] = 1'b0;
    ld_last[k]  = 1'b0;
  endtask

  // Single fetch; checks silence until the response, the response, then hold.
  task automatic fetch_resp(input int k, input logic [31:0] addr, input int lat,
                            input logic [31:0] exp_data, input logic exp_err,
                            input string tag);
    rd_en[k]   = 1'b1;
    rd_addr[k] = addr;
    step();
    rd_en[k] = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check({tag, "_early_valid"}, 32'(rd_valid[k]), 32'd0);
      step();
    end
    check({tag, "_valid"}, 32'(rd_valid[k]), 32'd1);
    check({tag, "_data"},  rd_data[k], exp_data);
    check({tag, "_err"},   32'(rd_err[k]), 32'(exp_err));
    step();
    check({tag, "_valid_drop"}, 32'(rd_valid[k]), 32'd0);
    check({tag, "_err_idle"},   32'(rd_err[k]), 32'd0);
    check({tag, "_data_hold"},  rd_data[k], exp_data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    img[0] = 32'h0010_0093;
    img[1] = 32'h0020_0113;
    img[2] = 32'h0020_81B3;
    img[3] = 32'h0000_0000;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd_en[k] = 1'b0; rd_addr[k] = '0; ld_valid[k] = 1'b0;
      ld_data[k] = '0; ld_last[k] = 1'b0; ld_restart[k] = 1'b0;
    end
    #1;
    check("rst_busy",     32'(busy[0]),     32'd1);
    check("rst_ready",    32'(ld_ready[0]), 32'd1);
    check("rst_gnt",      32'(rd_gnt[0]),   32'd0);
    check("rst_valid",    32'(rd_valid[0]), 32'd0);
    check("rst_data",     rd_data[0],       32'd0);
    check("rst_count",    count_of(0),      32'd0);
    check("rst_overflow", 32'(ld_overflow[0]), 32'd0);
    step(); step();
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // Test 1: load 4 words, back-to-back fetches at latency 1
    for (int i = 0; i < 3; i++) load_word(0, img[i], 1'b0);
    check("t1_busy_before_last", 32'(busy[0]), 32'd1);
    load_word(0, img[3], 1'b1);
    check("t1_busy_after_last", 32'(busy[0]), 32'd0);
    check("t1_count",           count_of(0),   32'd4);
    check("t1_gnt",             32'(rd_gnt[0]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(img[i]);
      rd_en[0]   = 1'b1;
      rd_addr[0] = 32'(4 * i);
      step();
      check("t1_b2b_valid", 32'(rd_valid[0]), 32'd1);
      check("t1_b2b_data",  rd_data[0], exp_q.pop_front());
      check("t1_b2b_err",   32'(rd_err[0]), 32'd0);
    end
    rd_en[0] = 1'b0;
    step();
    check("t1_idle_valid", 32'(rd_valid[0]), 32'd0);

    // Test 2: latency 3, single fetch at 0x8
    for (int i = 0; i < 4; i++) load_word(1, img[i], i == 3);
    fetch_resp(1, 32'h8, 3, 32'h0020_81B3, 1'b0, "t2_lat3");

    // Test 3: misaligned and out-of-range fetches pipelined with a good one
    exp_q.push_back(32'h0);          exp_err_q.push_back(1'b1);
    exp_q.push_back(32'h0);          exp_err_q.push_back(1'b1);
    exp_q.push_back(32'h0020_0113);  exp_err_q.push_back(1'b0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      rd_en[1] = (cyc < 3);
      case (cyc)
        0:       rd_addr[1] = 32'h6;
        1:       rd_addr[1] = 32'h40;
        default: rd_addr[1] = 32'h4;
      endcase
      step();
      if (cyc >= 2 && exp_q.size() > 0) begin
        check("t3_valid", 32'(rd_valid[1]), 32'd1);
        check("t3_data",  rd_data[1], exp_q.pop_front());
        check("t3_err",   32'(rd_err[1]), 32'(exp_err_q.pop_front()));
      end else begin
        check("t3_quiet_valid", 32'(rd_valid[1]), 32'd0);
        check("t3_quiet_err",   32'(rd_err[1]),   32'd0);
      end
    end
    check("t3_data_hold", rd_data[1], 32'h0020_0113);

    // Test 4: 16-word array, 18-word image
    for (int i = 0; i < 16; i++) load_word(2, 32'hA000_0000 + 32'(i), 1'b0);
    check("t4_count_full", count_of(2), 32'd16);
    check("t4_no_ovf_yet", 32'(ld_overflow[2]), 32'd0);
    load_word(2, 32'hA000_0010, 1'b0);
    load_word(2, 32'hA000_0011, 1'b1);
    check("t4_count_sat", count_of(2), 32'd16);
    check("t4_overflow",  32'(ld_overflow[2]), 32'd1);
    check("t4_run",       32'(busy[2]), 32'd0);
    fetch_resp(2, 32'h0,  2, 32'hA000_0000, 1'b0, "t4_w0");
    fetch_resp(2, 32'h3C, 2, 32'hA000_000F, 1'b0, "t4_w15");

    // Test 5: restart with one fetch in flight and one granted alongside it
    rd_en[2] = 1'b1; rd_addr[2] = 32'h0;
    step();
    rd_addr[2] = 32'h4; ld_restart[2] = 1'b1;
    check("t5_gnt_on_restart", 32'(rd_gnt[2]), 32'd1);
    step();
    rd_en[2] = 1'b0; ld_restart[2] = 1'b0;
    check("t5_busy",     32'(busy[2]), 32'd1);
    check("t5_count",    count_of(2), 32'd0);
    check("t5_ovf_clr",  32'(ld_overflow[2]), 32'd0);
    check("t5_gnt_load", 32'(rd_gnt[2]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("t5_flushed_valid", 32'(rd_valid[2]), 32'd0);
      step();
    end
    check("t5_data_hold", rd_data[2], 32'hA000_000F);
    load_word(2, 32'h1111_1111, 1'b0);
    load_word(2, 32'h2222_2222, 1'b1);
    fetch_resp(2, 32'h4, 2, 32'h2222_2222, 1'b0, "t5_reload");

    // Test 6: async reset mid-load keeps written words
    fetch_resp(0, 32'h0, 1, 32'h0010_0093, 1'b0, "t6_pre");
    ld_restart[0] = 1'b1;
    step();
    ld_restart[0] = 1'b0;
    load_word(0, 32'hDEAD_0001, 1'b0);
    load_word(0, 32'hDEAD_0002, 1'b0);
    check("t6_count_mid", count_of(0), 32'd2);
    #2;
    rst[0] = 1'b1;
    #1;
    check("t6_rst_count", count_of(0), 32'd0);
    check("t6_rst_busy",  32'(busy[0]), 32'd1);
    check("t6_rst_data",  rd_data[0], 32'd0);
    check("t6_rst_valid", 32'(rd_valid[0]), 32'd0);
    step();
    rst[0] = 1'b0;
    load_word(0, 32'hCAFE_0000, 1'b1);
    check("t6_count_after", count_of(0), 32'd1);
    fetch_resp(0, 32'h4, 1, 32'hDEAD_0002, 1'b0, "t6_kept");
    fetch_resp(0, 32'h0, 1, 32'hCAFE_0000, 1'b0, "t6_new");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jedro_1_imem_responder.md
Name: jedro_1_imem_responder

Overview:
Instruction-memory responder: the slave end of the core's instruction-fetch read interface. It answers word fetches from the jedro_1 core with a fixed, parameterised latency.
- Also contains a sequential program-loader write port that fills the memory before execution starts. This replaces file-initialised ROMs, so one image can be reloaded at runtime.
- Sits between the bench/SoC loader and jedro_1_top's instruction-memory master port.

Parameters:
DATA_WIDTH, 32, instruction word width
ADDR_WIDTH, 32, fetch byte-address width
DEPTH_WORDS, 256, memory depth in words; power of two, 16..4096
READ_LATENCY, 1, cycles from accepted fetch to rd_valid_o; legal range 1..4

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
rd_en_i  in  1  fetch request from core
rd_addr_i  in  ADDR_WIDTH  fetch byte address
rd_gnt_o  out  1  fetch accepted this cycle (combinational: high when state RUN)
rd_data_o  out  DATA_WIDTH  fetched instruction
rd_valid_o  out  1  rd_data_o valid
rd_err_o  out  1  fetch was misaligned or out of range, qualified by rd_valid_o
ld_valid_i  in  1  loader word valid
ld_data_i  in  DATA_WIDTH  loader word
ld_last_i  in  1  final word of image, qualified by ld_valid_i
ld_ready_o  out  1  loader may transfer (high when state LOAD)
ld_restart_i  in  1  return to LOAD from RUN
ld_count_o  out  $clog2(DEPTH_WORDS)+1  words written since last LOAD entry
ld_overflow_o  out  1  sticky: image exceeded DEPTH_WORDS
busy_o  out  1  high in LOAD

Behaviour:
- Reset (async, rst_i=1):
  - state=LOAD; pipeline valid bits cleared; ld_count_o=0; ld_overflow_o=0.
  - rd_valid_o=0, rd_err_o=0, rd_data_o=0.
  - Memory array is not reset; contents are retained across reset.
- States:
  - LOAD: ld_ready_o=1, rd_gnt_o=0, busy_o=1.
  - RUN: ld_ready_o=0, rd_gnt_o=1, busy_o=0.
- LOAD transfers:
  - Transfer when ld_valid_i & ld_ready_o.
  - If ld_count_o < DEPTH_WORDS, write mem[ld_count_o] = ld_data_i and increment ld_count_o.
  - Otherwise drop the word and set ld_overflow_o; ld_count_o saturates at DEPTH_WORDS.
- LOAD -> RUN: the transfer carrying ld_last_i is written (if in range), and the state is RUN next cycle.
  - ld_last_i without ld_valid_i is ignored.
- RUN -> LOAD on ld_restart_i:
  - Next cycle: ld_count_o=0, ld_overflow_o=0, all in-flight fetches flushed (rd_valid_o never asserts for them).
  - A fetch presented in the same cycle as ld_restart_i is still granted (rd_gnt_o is combinational on state) but is flushed, so it produces no response.
  - ld_restart_i in LOAD is ignored.
- Fetch acceptance: accepted when rd_en_i & rd_gnt_o. Word index = rd_addr_i[$clog2(DEPTH_WORDS)+1:2].
- Fetch error: rd_err_o=1 and rd_data_o=0 (illegal instruction) if either:
  - rd_addr_i[1:0] != 0, or
  - upper address bits select beyond DEPTH_WORDS.
- Fetch latency:
  - Response appears exactly READ_LATENCY cycles after acceptance: rd_valid_o=1 for one cycle with rd_data_o/rd_err_o.
  - Fully pipelined: one accept per cycle, responses in order, no bubbles for back-to-back fetches.
- Output hold:
  - rd_data_o holds its last value when rd_valid_o=0.
  - rd_err_o is 0 whenever rd_valid_o=0.
- Fetch requests in LOAD are not granted; the core must hold rd_en_i/rd_addr_i.
- Read-during-load hazard cannot occur, because reads are only granted in RUN.
- An asynchronous reset during LOAD or RUN aborts the image and flushes the pipeline. Words already written remain in memory.

Test Plan:
1. Reset, load 4 words {0x00100093, 0x00200113, 0x002081B3, 0x00000000} with ld_last_i on the 4th -> ld_count_o=4, busy_o falls the cycle after last. Fetch 0x0,0x4,0x8,0xC back-to-back with READ_LATENCY=1 -> rd_valid_o high 4 consecutive cycles with those words in order, rd_err_o=0.
2. READ_LATENCY=3, single fetch at 0x8 -> rd_valid_o exactly 3 cycles after the accept, data 0x002081B3.
3. Fetch 0x6 (misaligned), and with DEPTH_WORDS=16 fetch 0x40 -> rd_valid_o with rd_err_o=1, rd_data_o=0.
4. DEPTH_WORDS=16, load 18 words, last on 18th -> ld_count_o=16, ld_overflow_o=1, state RUN, mem[15] = 16th word.
5. Two fetches in flight (READ_LATENCY=2), assert ld_restart_i -> no rd_valid_o for either, busy_o=1, ld_count_o=0. Reload, then fetch -> new data returned.
6. Assert rst_i asynchronously mid-load after 2 words -> outputs reset immediately, state LOAD, ld_count_o=0. Reload 1 word and fetch 0x4 -> returns the word written before reset.
